// File: rtl/sprite_capture.sv
// -----------------------------------------------------------------------------
// sprite_capture
//
// Purpose: deserializes a horizontally mirrored 16x16 sprite from a serial
// pixel stream into sixteen 8-bit bitmap rows. This is the write-side inverse
// of the sprite renderer.
//   - The left half of each line (x = 0..7) is stored as row bits 0..7.
//   - The right half (x = 8..15) is only compared against the stored left half.
//     Any disagreement raises a sticky mismatch flag.
//
// Ports:
//   clk          in   sole clock, rising edge
//   reset        in   asynchronous active-low reset
//   vstart       in   arm capture of a new sprite (accepted only in IDLE)
//   hstart       in   first pixel of a row follows (accepted only in WAIT_HSTART)
//   pixel_in     in   serial pixel, one per clk
//   wr_addr[3:0] out  bitmap RAM row address (registered, held between writes)
//   wr_bits[7:0] out  bitmap row data (registered, held between writes)
//   wr_en        out  one-cycle write strobe, high exactly while in WRITE
//   in_progress  out  high whenever the FSM is not IDLE
//   done         out  one-cycle pulse coincident with the row-15 write
//   mismatch     out  sticky: some right-half pixel was not the mirror of its
//                     left-half counterpart; cleared when vstart is accepted
// -----------------------------------------------------------------------------
module sprite_capture (
  input  logic       clk,
  input  logic       reset,
  input  logic       vstart,
  input  logic       hstart,
  input  logic       pixel_in,
  output logic [3:0] wr_addr,
  output logic [7:0] wr_bits,
  output logic       wr_en,
  output logic       in_progress,
  output logic       done,
  output logic       mismatch
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_HSTART = 2'd1,
    SAMPLE      = 2'd2,
    WRITE       = 2'd3
  } state_t;

  state_t     r_state;
  logic [3:0] r_xcount;
  logic [3:0] r_ycount;
  logic [7:0] r_row;
  logic [3:0] r_wr_addr;
  logic [7:0] r_wr_bits;
  logic       r_wr_en;
  logic       r_done;
  logic       r_mismatch;

  // Bit of the stored left half that mirrors the current right-half pixel:
  // x = 8..15 maps to bit 7..0, i.e. the inverted low three bits of xcount.
  logic [2:0] w_mirror_idx;
  assign w_mirror_idx = ~r_xcount[2:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_xcount   <= 4'd0;
      r_ycount   <= 4'd0;
      r_row      <= 8'd0;
      r_wr_addr  <= 4'd0;
      r_wr_bits  <= 8'd0;
      r_wr_en    <= 1'b0;
      r_done     <= 1'b0;
      r_mismatch <= 1'b0;
    end else begin
      // Strobes default low and are raised only on the edge entering WRITE.
      // As a result, they are high for exactly the one WRITE cycle.
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;

      case (r_state)
        IDLE: begin
          r_ycount <= 4'd0;
          r_xcount <= 4'd0;
          if (vstart) begin
            r_mismatch <= 1'b0;
            r_state    <= WAIT_HSTART;
          end
        end

        WAIT_HSTART: begin
          r_xcount <= 4'd0;
          if (hstart) begin
            r_state <= SAMPLE;
          end
        end

        SAMPLE: begin
          // hstart/vstart are deliberately not looked at here, so a line is
          // never restarted once sampling has begun.
          if (!r_xcount[3]) begin
            r_row[r_xcount[2:0]] <= pixel_in;
          end else if (pixel_in != r_row[w_mirror_idx]) begin
            r_mismatch <= 1'b1;
          end
          r_xcount <= r_xcount + 4'd1;

          if (r_xcount == 4'd15) begin
            // The left half was complete at x = 7, so r_row is final here.
            // The outputs are registered, so they are valid during WRITE.
            r_state   <= WRITE;
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_ycount;
            r_wr_bits <= r_row;
            r_done    <= (r_ycount == 4'd15);
          end
        end

        WRITE: begin
          r_ycount <= r_ycount + 4'd1;
          if (r_ycount == 4'd15) begin
            r_state <= IDLE;
          end else begin
            r_state <= WAIT_HSTART;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign wr_addr     = r_wr_addr;
  assign wr_bits     = r_wr_bits;
  assign wr_en       = r_wr_en;
  assign done        = r_done;
  assign mismatch    = r_mismatch;
  assign in_progress = (r_state != IDLE);

endmodule

// File: tb/tb_sprite_capture.sv
// -----------------------------------------------------------------------------
// tb_sprite_capture
//
// Purpose: randomized scoreboard bench for sprite_capture.
//   - Each issued row pushes its expected write (address, data, done, cycle)
//     into a queue.
//   - A monitor pops and compares entries whenever wr_en is seen.
//   - The reference model works directly on 16-pixel lines:
//       - expected row   = left eight pixels;
//       - expected flag  = any right pixel differing from its mirror partner.
// -----------------------------------------------------------------------------
module tb_sprite_capture;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       vstart = 1'b0;
  logic       hstart = 1'b0;
  logic       pixel_in = 1'b0;
  logic [3:0] wr_addr;
  logic [7:0] wr_bits;
  logic       wr_en;
  logic       in_progress;
  logic       done;
  logic       mismatch;

  sprite_capture dut (
    .clk        (clk),
    .reset      (reset),
    .vstart     (vstart),
    .hstart     (hstart),
    .pixel_in   (pixel_in),
    .wr_addr    (wr_addr),
    .wr_bits    (wr_bits),
    .wr_en      (wr_en),
    .in_progress(in_progress),
    .done       (done),
    .mismatch   (mismatch)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  addr;
    logic [7:0]  bits;
    logic        dn;
    int unsigned at;
  } exp_t;

  exp_t        q[$];
  int          n_total = 0;
  int          n_pass  = 0;
  logic        model_mm = 1'b0;
  logic [15:0] sprite_pix [16];
  logic [7:0]  car_rom [16];
  logic [7:0]  captured [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: checks each write strobe against the head of the scoreboard.
  always @(posedge clk) begin
    #1;
    if (reset && wr_en) begin
      if (q.size() == 0) begin
        chk("unexpected_write", 32'(wr_en), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e.addr));
        chk("wr_bits", 32'(wr_bits), 32'(e.bits));
        chk("done_with_write", 32'(done), 32'(e.dn));
        chk("write_latency_cycle", cyc, e.at);
        captured[wr_addr] = wr_bits;
        $display("write addr=%0d bits=%02h done=%0b mismatch=%0b", wr_addr, wr_bits, done, mismatch);
      end
    end else if (reset && done) begin
      chk("done_without_wr_en", 32'(done), 32'd0);
    end
  end

  // Behavioural renderer: the pixel at column x shows bitmap bit x for the
  // left half and bit 15-x for the right half.
  function automatic logic [15:0] mirror(input logic [7:0] b);
    logic [15:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i]      = b[i];
      r[15 - i] = b[i];
    end
    return r;
  endfunction

  task automatic do_vstart();
    @(negedge clk);
    vstart = 1'b1;
    @(negedge clk);
    vstart = 1'b0;
    model_mm = 1'b0;
  endtask

  task automatic send_row(input logic [15:0] pix, input int y, input bit noise,
                          input int abort_x, output bit aborted);
    exp_t e;
    aborted = 1'b0;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    @(negedge clk);
    hstart = 1'b1;
    e.addr = y[3:0];
    e.bits = pix[7:0];
    e.dn   = (y == 15);
    e.at   = cyc + 17;
    q.push_back(e);
    for (int x = 8; x < 16; x++) begin
      if (pix[x] != pix[15 - x]) model_mm = 1'b1;
    end
    for (int x = 0; x < 16; x++) begin
      @(negedge clk);
      hstart = 1'b0;
      vstart = 1'b0;
      if (x == abort_x) begin
        #2 reset = 1'b0;
        #1;
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_bits", 32'(wr_bits), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_mismatch", 32'(mismatch), 32'd0);
        chk("rst_in_progress", 32'(in_progress), 32'd0);
        void'(q.pop_back());
        model_mm = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        aborted = 1'b1;
        return;
      end
      pixel_in = pix[x];
      if (noise && x == 5) begin
        hstart = 1'b1;
        vstart = 1'b1;
      end
      chk("in_progress_sample", 32'(in_progress), 32'd1);
    end
    @(negedge clk);
    pixel_in = 1'b0;
    hstart = 1'b0;
    vstart = 1'b0;
    $display("row y=%0d pixels=%04h sent", y, pix);
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("write_queue_drained", q.size(), 32'd0);
  endtask

  task automatic run_sprite(input bit with_vstart, input bit noise);
    bit ab;
    if (with_vstart) do_vstart();
    for (int y = 0; y < 16; y++) begin
      send_row(sprite_pix[y], y, noise, -1, ab);
    end
    drain();
    repeat (2) @(negedge clk);
    chk("mismatch_after_sprite", 32'(mismatch), 32'(model_mm));
    chk("idle_after_sprite", 32'(in_progress), 32'd0);
  endtask

  task automatic fill_random(input int corrupt_pct);
    for (int y = 0; y < 16; y++) begin
      sprite_pix[y] = mirror(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 99) < corrupt_pct) begin
        sprite_pix[y][8 + $urandom_range(0, 7)] ^= 1'b1;
      end
    end
  endtask

  initial begin
    bit ab;
    car_rom = '{8'h00, 8'h18, 8'h3C, 8'h3C, 8'h7E, 8'h66, 8'h7E, 8'hFF,
                8'hFF, 8'h7E, 8'h3C, 8'h7E, 8'hFF, 8'h66, 8'h66, 8'h00};
    for (int i = 0; i < 16; i++) captured[i] = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_wr_addr", 32'(wr_addr), 32'd0);
    chk("reset_wr_bits", 32'(wr_bits), 32'd0);
    chk("reset_wr_en", 32'(wr_en), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_mismatch", 32'(mismatch), 32'd0);
    chk("reset_in_progress", 32'(in_progress), 32'd0);
    reset = 1'b1;

    // hstart without vstart: nothing happens
    @(negedge clk);
    hstart = 1'b1;
    @(negedge clk);
    hstart = 1'b0;
    repeat (20) @(negedge clk);
    chk("no_vstart_in_progress", 32'(in_progress), 32'd0);

    // Clean 0x5A sprite
    for (int y = 0; y < 16; y++) sprite_pix[y] = mirror(8'h5A);
    run_sprite(1'b1, 1'b0);
    chk("clean_mismatch_zero", 32'(mismatch), 32'd0);

    // Row 3, x = 12 inverted
    sprite_pix[3][12] ^= 1'b1;
    run_sprite(1'b1, 1'b0);
    chk("mismatch_set", 32'(mismatch), 32'd1);
    repeat (10) @(negedge clk);
    chk("mismatch_held_idle", 32'(mismatch), 32'd1);
    do_vstart();
    chk("mismatch_cleared_by_vstart", 32'(mismatch), 32'd0);
    fill_random(0);
    run_sprite(1'b0, 1'b0);

    // hstart/vstart pulsed during SAMPLE
    fill_random(20);
    run_sprite(1'b1, 1'b1);

    // Asynchronous reset at xcount 9 of row 7, then a full sprite
    fill_random(0);
    sprite_pix[2][9] ^= 1'b1;
    do_vstart();
    for (int y = 0; y < 7; y++) send_row(sprite_pix[y], y, 1'b0, -1, ab);
    send_row(sprite_pix[7], 7, 1'b0, 9, ab);
    repeat (20) @(negedge clk);
    chk("after_reset_idle", 32'(in_progress), 32'd0);
    fill_random(0);
    run_sprite(1'b1, 1'b0);

    // Loopback of the car bitmap through the renderer model
    for (int y = 0; y < 16; y++) sprite_pix[y] = mirror(car_rom[y]);
    run_sprite(1'b1, 1'b0);
    for (int y = 0; y < 16; y++) chk("car_rom_row", 32'(captured[y]), 32'(car_rom[y]));

    // Random sprites
    for (int s = 0; s < 3; s++) begin
      fill_random(15);
      run_sprite(1'b1, ($urandom_range(0, 1) == 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
